i2c_pos_reader: RTL and testbench

- I2C master that reads the position/status record from the chip's I2C slave.
- One transaction is: START, address+R, three data bytes (x_pos, y_pos, status), STOP.
- Lives in the companion controller/test-harness design on the same bus.
- Drives open-drain SCL/SDA enables and presents the last good record as registers, with a start/busy/done handshake.

---
 rtl/i2c_pos_reader.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_pos_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_pos_reader.sv
// ---------------------------------------------------------------------------
// i2c_pos_reader
//
// I2C master that fetches the three-byte position/status record from the
// chip's I2C slave: START, address+R, x_pos, y_pos, status, STOP.
// The last complete record is held in output registers; a record is only
// published once all three bytes have been received.
//
// Every bit slot is four quarters (Q0 SCL low / SDA set, Q1 SCL released,
// Q2 SCL high / SDA sampled on the last tick, Q3 SCL low).  One quarter is
// CLK_DIV clock cycles.
//
// Optional feature (macro I2C_CLOCK_STRETCH_EN): when defined, the quarter
// divider stalls in Q1/Q2 while scl_in is low, so a slave stretching SCL
// lengthens the high phase and sampling waits until SCL is really high.
// When undefined, scl_in is ignored and timing is purely divider based.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   start    in   one-cycle request to begin a read (ignored while busy)
//   scl_in   in   sampled SCL pad level
//   sda_in   in   sampled SDA pad level
//   scl_oe   out  1 = pull SCL low, 0 = release
//   sda_oe   out  1 = pull SDA low, 0 = release
//   busy     out  transaction in progress
//   done     out  one-cycle pulse after the transaction ends
//   ack_err  out  address was NACKed on the last transaction (sticky)
//   x_pos    out  first byte of the last good record
//   y_pos    out  second byte of the last good record
//   status   out  third byte of the last good record
// ---------------------------------------------------------------------------
module i2c_pos_reader #(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] SLAVE_ADDR = 7'h64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic [7:0] status
);

    localparam int               DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       ADDR_BYTE = {SLAVE_ADDR, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_READ, S_MACK, S_STOP, S_DONE
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_q;        // quarter within the current slot
    logic [2:0]       r_bit;      // bit within the current byte
    logic [1:0]       r_idx;      // data byte index 0..2
    logic [7:0]       r_shift;
    logic [7:0]       r_byte0;
    logic [7:0]       r_byte1;
    logic [7:0]       r_x;
    logic [7:0]       r_y;
    logic [7:0]       r_status;
    logic             r_busy;
    logic             r_done;
    logic             r_ack_err;
    logic             r_scl_oe;
    logic             r_sda_oe;
    logic             w_hold;
    logic             w_tick;

`ifdef I2C_CLOCK_STRETCH_EN
    // Our own SCL is released in Q1/Q2; a low level there means the slave
    // is stretching, so the quarter must not advance.
    assign w_hold = r_busy && ((r_q == 2'd1) || (r_q == 2'd2)) && !scl_in;
`else
    logic w_unused_scl;
    assign w_unused_scl = scl_in;
    assign w_hold       = 1'b0;
`endif

    assign w_tick = r_busy && (r_div == DIV_LAST) && !w_hold;

    // Line levels are registered and updated on the tick that enters a
    // quarter, so scl_oe/sda_oe always reflect the quarter being executed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_idx     <= 2'd0;
            r_shift   <= 8'h00;
            r_byte0   <= 8'h00;
            r_byte1   <= 8'h00;
            r_x       <= 8'h00;
            r_y       <= 8'h00;
            r_status  <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (!r_busy) begin
                r_div <= '0;
            end else if (!w_hold) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_START;
                        r_busy    <= 1'b1;
                        r_ack_err <= 1'b0;
                        r_q       <= 2'd0;
                        r_scl_oe  <= 1'b0;
                        r_sda_oe  <= 1'b0;
                    end
                end

                S_DONE: r_state <= S_IDLE;

                default: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        if (r_q != 2'd3) begin
                            // Entering Q1, Q2 or Q3 of the same slot
                            case (r_q)
                                2'd0: r_scl_oe <= 1'b0;
                                2'd1: begin
                                    // START condition: SDA falls while SCL high
                                    if (r_state == S_START) r_sda_oe <= 1'b1;
                                end
                                default: begin
                                    // STOP condition: SDA rises while SCL high
                                    if (r_state == S_STOP) r_sda_oe <= 1'b0;
                                    else                   r_scl_oe <= 1'b1;
                                end
                            endcase
                            if ((r_q == 2'd2) &&
                                ((r_state == S_ADDR_ACK) || (r_state == S_READ))) begin
                                r_shift <= {r_shift[6:0], sda_in};
                            end
                        end else begin
                            // End of slot: choose the next slot and its Q0 levels
                            case (r_state)
                                S_START: begin
                                    r_state  <= S_ADDR;
                                    r_bit    <= 3'd0;
                                    r_scl_oe <= 1'b1;
                                    r_sda_oe <= ~ADDR_BYTE[7];
                                end
                                S_ADDR: begin
                                    r_scl_oe <= 1'b1;
                                    if (r_bit == 3'd7) begin
                                        r_state  <= S_ADDR_ACK;
                                        r_sda_oe <= 1'b0;
                                    end else begin
                                        r_bit    <= r_bit + 3'd1;
                                        r_sda_oe <= ~ADDR_BYTE[3'd6 - r_bit];
                                    end
                                end
                                S_ADDR_ACK: begin
                                    r_scl_oe <= 1'b1;
                                    if (r_shift[0]) begin
                                        r_ack_err <= 1'b1;
                                        r_state   <= S_STOP;
                                        r_sda_oe  <= 1'b1;
                                    end else begin
                                        r_state  <= S_READ;
                                        r_bit    <= 3'd0;
                                        r_idx    <= 2'd0;
                                        r_sda_oe <= 1'b0;
                                    end
                                end
                                S_READ: begin
                                    r_scl_oe <= 1'b1;
                                    if (r_bit == 3'd7) begin
                                        r_state  <= S_MACK;
                                        // ACK bytes 0 and 1, NACK the last one
                                        r_sda_oe <= (r_idx != 2'd2);
                                    end else begin
                                        r_bit    <= r_bit + 3'd1;
                                        r_sda_oe <= 1'b0;
                                    end
                                end
                                S_MACK: begin
                                    r_scl_oe <= 1'b1;
                                    case (r_idx)
                                        2'd0:    r_byte0 <= r_shift;
                                        2'd1:    r_byte1 <= r_shift;
                                        default: begin
                                            // Publish the whole record at once
                                            r_x      <= r_byte0;
                                            r_y      <= r_byte1;
                                            r_status <= r_shift;
                                        end
                                    endcase
                                    if (r_idx == 2'd2) begin
                                        r_state  <= S_STOP;
                                        r_sda_oe <= 1'b1;
                                    end else begin
                                        r_state  <= S_READ;
                                        r_bit    <= 3'd0;
                                        r_idx    <= r_idx + 2'd1;
                                        r_sda_oe <= 1'b0;
                                    end
                                end
                                S_STOP: begin
                                    r_state  <= S_DONE;
                                    r_busy   <= 1'b0;
                                    r_done   <= 1'b1;
                                    r_scl_oe <= 1'b0;
                                    r_sda_oe <= 1'b0;
                                end
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign scl_oe  = r_scl_oe;
    assign sda_oe  = r_sda_oe;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign x_pos   = r_x;
    assign y_pos   = r_y;
    assign status  = r_status;

endmodule

// File: tb/tb_i2c_pos_reader.sv
// ---------------------------------------------------------------------------
// Testbench for i2c_pos_reader.  A behavioural I2C slave watches the
// open-drain bus at the bit level (START/STOP/edge detection) and serves a
// three-byte record; expected results come from protocol-level arithmetic.
// ---------------------------------------------------------------------------
module tb_i2c_pos_reader;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       scl_oe, sda_oe, busy, done, ack_err;
    logic [7:0] x_pos, y_pos, status;

    // Bus with pull-ups: low if anyone pulls
    logic scl_hold;
    logic s_drive;
    logic scl_line, sda_line;
    assign scl_line = ~(scl_oe | scl_hold);
    assign sda_line = ~(sda_oe | s_drive);

    i2c_pos_reader #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'h64)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .scl_in  (scl_line),
        .sda_in  (sda_line),
        .scl_oe  (scl_oe),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .x_pos   (x_pos),
        .y_pos   (y_pos),
        .status  (status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    logic       present;
    logic       stretch_en;
    logic [7:0] s_data [3];
    logic [7:0] s_addr;
    logic [2:0] s_mack;
    int         s_byte    = 99;
    int         s_bit     = 0;
    int         hold_left = 0;
    int         stop_cnt  = 0;
    int         done_cnt  = 0;
    logic       scl_p = 1'b1, sda_p = 1'b1;

    assign scl_hold = (hold_left > 0);

    initial s_drive = 1'b0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (hold_left > 0) hold_left--;
        if (rst) begin
            s_drive   = 1'b0;
            s_byte    = 99;
            hold_left = 0;
        end else if (scl_p && scl_line && sda_p && !sda_line) begin
            s_byte  = 0;
            s_bit   = -1;
            s_drive = 1'b0;
        end else if (scl_p && scl_line && !sda_p && sda_line) begin
            stop_cnt++;
        end else if (!scl_p && scl_line) begin
            if (s_byte == 0 && s_bit >= 0 && s_bit < 8) s_addr = {s_addr[6:0], sda_line};
            if (s_byte >= 1 && s_byte <= 3 && s_bit == 8) s_mack[s_byte-1] = sda_line;
        end else if (scl_p && !scl_line) begin
            s_bit++;
            if (s_bit == 9) begin
                s_bit = 0;
                s_byte++;
            end
            s_drive = 1'b0;
            if (present && s_addr == 8'hC9) begin
                if (s_byte == 0 && s_bit == 8) s_drive = 1'b1;
                if (s_byte >= 1 && s_byte <= 3 && s_bit < 8)
                    s_drive = ~s_data[s_byte-1][7-s_bit];
            end
            if (stretch_en && s_byte == 0 && s_bit == 3) hold_left = 50;
        end
        scl_p = scl_line;
        sda_p = sda_line;
    end

    // ---------------- reference record ----------------
    logic [7:0] exp_x = 8'h00, exp_y = 8'h00, exp_st = 8'h00;
    int         txn_no = 0;

    task automatic do_read(input logic pres, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input int inj_a, input int inj_b,
                           input logic stretch);
        int cnt;
        int dc0, sc0, exp_busy;
        present    = pres;
        stretch_en = stretch;
        s_data[0]  = d0;
        s_data[1]  = d1;
        s_data[2]  = d2;
        s_mack     = 3'b010;
        s_addr     = 8'h00;
        dc0        = done_cnt;
        sc0        = stop_cnt;
        cnt        = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("ack_err_cleared_at_start", ack_err, 1'b0);
        while (busy && cnt < 20000) begin
            cnt++;
            start = (cnt == inj_a || cnt == inj_b);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_after_busy", done, 1'b1);
        exp_busy = (pres ? (4 + 36 * 4 + 4) : (4 + 9 * 4 + 4)) * CLK_DIV;
        if (stretch) begin
            chk("busy_stretched_window",
                (cnt >= exp_busy + 40 && cnt <= exp_busy + 55), 1'b1);
        end else begin
            chk("busy_cycles", cnt, exp_busy);
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - dc0, 1);
        chk("stop_seen", stop_cnt - sc0, 1);
        chk("addr_byte", s_addr, (8'h64 << 1) | 8'h01);
        chk("bus_idle_scl", scl_oe, 1'b0);
        chk("bus_idle_sda", sda_oe, 1'b0);
        chk("busy_low", busy, 1'b0);
        if (pres) begin
            exp_x  = d0;
            exp_y  = d1;
            exp_st = d2;
            chk("master_ack_bits", s_mack, 3'b100);
        end
        chk("ack_err", ack_err, !pres);
        chk("x_pos", x_pos, exp_x);
        chk("y_pos", y_pos, exp_y);
        chk("status", status, exp_st);
        txn_no++;
        $display("txn %0d: slave=%0d data=%02h/%02h/%02h busy=%0d ack_err=%0d rec=%02h/%02h/%02h",
                 txn_no, pres, d0, d1, d2, cnt, ack_err, x_pos, y_pos, status);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        present    = 1'b1;
        stretch_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_scl_oe", scl_oe, 1'b0);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_x", x_pos, 8'h00);
        chk("rst_y", y_pos, 8'h00);
        chk("rst_status", status, 8'h00);

        // Directed read with extra start pulses during the transaction
        do_read(1'b1, 8'h12, 8'h34, 8'hC9, 10, 300, 1'b0);
        // No slave: address NACK, record kept
        do_read(1'b0, 8'hAA, 8'hBB, 8'hCC, 0, 0, 1'b0);
        // ack_err must clear on the next good read
        do_read(1'b1, 8'h5A, 8'hA5, 8'h0F, 0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_read(($urandom_range(0, 3) != 0),
                    8'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(1, 600), $urandom_range(1, 600), 1'b0);
        end

        // Reset in the middle of a transaction
        do_read(1'b1, 8'h77, 8'h88, 8'h99, 0, 0, 1'b0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (199) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_scl_oe", scl_oe, 1'b0);
        chk("midrst_sda_oe", sda_oe, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_x", x_pos, 8'h00);
        chk("midrst_y", y_pos, 8'h00);
        chk("midrst_status", status, 8'h00);
        rst    = 1'b0;
        exp_x  = 8'h00;
        exp_y  = 8'h00;
        exp_st = 8'h00;
        repeat (5) @(negedge clk);
        do_read(1'b1, 8'h12, 8'h34, 8'hC9, 0, 0, 1'b0);

`ifdef I2C_CLOCK_STRETCH_EN
        do_read(1'b1, 8'h12, 8'h34, 8'hC9, 0, 0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
